// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct constants, resolver state and branch-compare encodings
package cpu_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;
  typedef enum logic [1:0] {IDLE, WAIT, SLOT} state_e;
  typedef enum logic [2:0] {BR_ALW, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ} br_op_e;
endpackage

// File: rtl/br_cmp.sv
// br_cmp: combinational branch-condition evaluator (signed compares)
module br_cmp
  import cpu_pkg::*;
(
  input  br_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);
  logic signed [31:0] a;
  assign a = a_i;
  always_comb
    taken_o = op_i == BR_EQ  ? a_i == b_i :
              op_i == BR_NE  ? a_i != b_i :
              op_i == BR_LEZ ? a <= 0 :
              op_i == BR_GTZ ? a > 0 :
              op_i == BR_LTZ ? a < 0 :
              op_i == BR_GEZ ? a >= 0 : 1'b1;
endmodule

// File: rtl/br_resolve.sv
// br_resolve: ID-stage jump/branch resolver with operand stall and single delay-slot tracking
module br_resolve
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic        OpndRdyD,
  input  logic        En,
  output logic        IsJBrD,
  output logic [31:0] NPCD,
  output logic [31:0] LinkD,
  output logic        StallBrD,
  output logic        DsErr
);
  state_e state_q, state_d;
  logic dserr_q, dserr_d;
  logic [5:0] op, fn;
  logic [4:0] rt;
  logic [15:0] imm;
  logic is_br, is_j, is_jr, cti, rdy, act, wait_c, issue, taken;
  logic [31:0] target;
  br_op_e cmp_op;
  assign op  = InstrD[31:26];
  assign rt  = InstrD[20:16];
  assign fn  = InstrD[5:0];
  assign imm = InstrD[15:0];
  always_comb begin
    is_br  = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ} || (op == OP_REGIMM && rt inside {RT_BLTZ, RT_BGEZ});
    is_j   = op == OP_J || op == OP_JAL;
    is_jr  = op == OP_SPECIAL && fn inside {FN_JR, FN_JALR};
    cti    = is_br | is_j | is_jr;
    cmp_op = !is_br          ? BR_ALW :
             op == OP_BEQ    ? BR_EQ  :
             op == OP_BNE    ? BR_NE  :
             op == OP_BLEZ   ? BR_LEZ :
             op == OP_BGTZ   ? BR_GTZ :
             rt == RT_BLTZ   ? BR_LTZ : BR_GEZ;
    target = is_j  ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} :
             is_jr ? RD1D : PCPlus4D + {{14{imm[15]}}, imm, 2'b00};
  end
  br_cmp u_cmp (.op_i(cmp_op), .a_i(RD1D), .b_i(RD2D), .taken_o(taken));
  // j/jal carry their target in the instruction and never wait on forwarding
  assign rdy    = is_j | OpndRdyD;
  assign act    = ValidD & cti & (state_q != SLOT);
  assign wait_c = act & ~rdy;
  assign issue  = act & rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dserr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dserr_q <= dserr_d;
    end
  always_comb begin
    state_d = state_q == SLOT ? ((En & ValidD) ? IDLE : SLOT) :
              wait_c          ? WAIT :
              (issue & En)    ? SLOT : IDLE;
    dserr_d = dserr_q | (state_q == SLOT & ValidD & cti);
  end
  always_comb begin
    IsJBrD   = rst_n & issue & taken;
    StallBrD = rst_n & wait_c;
    NPCD     = IsJBrD ? target : 32'h0;
    LinkD    = PCPlus4D + 32'd4;
    DsErr    = dserr_q;
  end
endmodule

// File: doc/br_resolve.md
# br_resolve

ID-stage control-transfer resolver for the pipelined MIPS core: decodes the instruction in ID, evaluates branch conditions, and produces the jump/branch request (IsJBrD) and target (NPCD) consumed by the IF-stage PC. It is the producer end of the PC's delayed-branch interface. It guarantees exactly one request per control-transfer instruction (CTI), stalls ID while a CTI's operands are not yet forwarded, and tracks the single delay slot so that a CTI in that slot is flagged instead of issued.

## Interface
- No parameters. Reset address and opcode/funct constants come from the shared package.
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction currently in ID.
- ValidD  in  1  ID holds a real instruction (0 = bubble).
- PCPlus4D  in  32  address of the ID instruction + 4.
- RD1D, RD2D  in  32  rs/rt operands after forwarding.
- OpndRdyD  in  1  RD1D/RD2D are final (forwarding unit); ignored for j/jal.
- En  in  1  pipeline advance enable (same signal the PC and IF/ID register use).
- IsJBrD  out  1  taken jump/branch request to the PC; NPCD valid while high.
- NPCD  out  32  control-transfer target.
- LinkD  out  32  return address for jal/jalr = PCPlus4D + 4.
- StallBrD  out  1  ID stall request to the hazard unit.
- DsErr  out  1  sticky: a CTI was found in a delay slot.

## Operation
- Recognised CTIs: beq, bne, blez, bgtz, bltz/bgez (REGIMM rt=0/1), j, jal, jr, jalr. Anything else is a non-CTI.
- Targets: branch = PCPlus4D + (sign-extended imm16 << 2), modulo 2^32; j/jal = {PCPlus4D[31:28], instr_index, 2'b00}; jr/jalr = RD1D, unmodified.
- Conditions: signed compare of RD1D (and RD2D for beq/bne). j/jal/jr/jalr are always taken. Untaken branch: IsJBrD=0, delay slot still tracked.
- FSM (registered state), reset state IDLE:
  - IDLE: ValidD & CTI & needs operands & !OpndRdyD -> WAIT (StallBrD=1). ValidD & CTI & ready: IsJBrD=taken; if En -> SLOT, else stay IDLE and keep asserting.
  - WAIT: StallBrD=1 and IsJBrD=0 while !OpndRdyD. Once ready, behave as IDLE-ready (En -> SLOT).
  - SLOT: instruction in ID is the delay slot. IsJBrD=0, StallBrD=0. If ValidD & CTI, set DsErr; the slot CTI is never issued. Leave to IDLE on En & ValidD; a bubble in SLOT keeps SLOT.
- IsJBrD, NPCD, LinkD, and StallBrD are combinational from state and ID inputs. NPCD = 0 whenever IsJBrD = 0.
- DsErr clears only on reset.

## Timing
- Zero-cycle latency: the request appears in the same cycle the CTI is decoded with ready operands. The PC captures it at the first posedge with En=1.
- Handshake: the request holds until accepted (IsJBrD & En at posedge). After acceptance it is never re-asserted for the same CTI.
- Operand stall: StallBrD is high for exactly as many cycles as OpndRdyD is low. The request is asserted in the first cycle OpndRdyD=1.
- Simultaneous StallBrD and En=1 cannot occur by construction. If it is presented anyway, state stays WAIT.
- Reset (async, any state, including mid-WAIT or SLOT): state=IDLE, DsErr=0. While rst_n=0, IsJBrD=0, StallBrD=0, NPCD=0. LinkD is combinational and unaffected.

## Structure
- Shared package (cpu_pkg): opcode/funct/REGIMM-rt constants, state enum {IDLE, WAIT, SLOT}, reset PC constant 32'h00003000.
- One sub-module, br_cmp: a purely combinational condition evaluator (op, RD1D, RD2D -> taken). All other logic is in br_resolve.

## Test plan
- beq with RD1D=RD2D=5, PCPlus4D=0x3008, imm=0x0004, OpndRdyD=1, En=1 -> IsJBrD=1 for one cycle, NPCD=0x3018; next cycle state SLOT, IsJBrD=0.
- bne with RD1D=RD2D -> IsJBrD=0, NPCD=0, StallBrD=0; the following instruction is treated as a delay slot.
- jr with RD1D=0x4000, OpndRdyD low for 2 cycles -> StallBrD=1 for 2 cycles, then IsJBrD=1, NPCD=0x4000.
- jal with index 0x0000C00, PCPlus4D=0x3008, En=0 for 3 cycles then 1 -> IsJBrD held high for 4 cycles, NPCD=0x3000, LinkD=0x300C; exactly one acceptance.
- j placed in the delay slot of a taken beq -> no second request, DsErr=1 and stays 1 until rst_n=0.
- rst_n pulsed low asynchronously mid-WAIT -> StallBrD and IsJBrD drop immediately; after release state is IDLE and a fresh bgtz (RD1D=1) issues normally.
